// File: rtl/ref_sin_dds_if.sv
// Tuning-word offer channel into the reference sine DDS.
// The master holds freq/freqValid until the one-cycle freqAck.
interface ref_sin_dds_if #(
  parameter int ACC_W = 32
);
  logic [ACC_W-1:0] freq;
  logic             freqValid;
  logic             freqAck;

  modport master (
    output freq,
    output freqValid,
    input  freqAck
  );

  modport slave (
    input  freq,
    input  freqValid,
    output freqAck
  );
endinterface

// File: rtl/ref_sin_dds.sv
// Reference sine DDS: phase accumulator, quarter-wave ROM, 3-clock pipe.
// Emits signed DAC samples and a one-cycle marker on the post-wrap sample.
module ref_sin_dds #(
  parameter int ACC_W  = 32,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  ref_sin_dds_if.slave            freqIf,
  input  logic [ACC_W-1:0]        phaseOffset,
  input  logic                    phaseLoad,
  output logic signed [OUT_W-1:0] toDAC,
  output logic                    sampleValid,
  output logic                    phaseSync
);

  localparam int LUT_N = 2 ** LUT_AW;

  function automatic int lutVal(input int k);
    real x;
    x = 32767.0 * $sin(3.14159265358979323846 * (real'(k) + 0.5)
        / real'(2 ** (LUT_AW + 1)));
    return $rtoi(x + 0.5);
  endfunction

  // Table is folded to constants at elaboration time.
  logic [OUT_W-2:0] lut [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : gLut
    localparam int V = lutVal(g);
    assign lut[g] = (OUT_W-1)'(V);
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw;
  logic [ACC_W-1:0] pendReg;
  logic             pending;
  logic             accWrap;
  logic             accEn;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             applyFtw;
  logic [1:0]       quad;
  logic [LUT_AW-1:0] idx;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, ftw};
    carry    = sum[ACC_W];
    applyFtw = pending &&
               (carry || phaseLoad || !enable || (ftw == '0));
    quad     = acc[ACC_W-1 -: 2];
    idx      = acc[ACC_W-3 -: LUT_AW];
  end

  // New tuning word lands only where it cannot cause a phase step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      ftw            <= '0;
      pendReg        <= '0;
      pending        <= 1'b0;
      accWrap        <= 1'b0;
      accEn          <= 1'b0;
      freqIf.freqAck <= 1'b0;
    end else begin
      if (phaseLoad) begin
        acc     <= phaseOffset;
        accWrap <= 1'b0;
      end else if (enable) begin
        acc     <= sum[ACC_W-1:0];
        accWrap <= carry;
      end else begin
        accWrap <= 1'b0;
      end
      accEn          <= enable;
      freqIf.freqAck <= applyFtw;
      if (applyFtw) begin
        ftw     <= pendReg;
        pending <= 1'b0;
      end else if (freqIf.freqValid && !pending) begin
        pendReg <= freqIf.freq;
        pending <= 1'b1;
      end
    end
  end

  logic [LUT_AW-1:0] s1Idx;
  logic              s1Neg;
  logic              s1Wrap;
  logic              s1En;
  logic [OUT_W-2:0]  s2Mag;
  logic              s2Neg;
  logic              s2Wrap;
  logic              s2En;
  logic [OUT_W-1:0]  magExt;

  assign magExt = {1'b0, s2Mag};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Idx       <= '0;
      s1Neg       <= 1'b0;
      s1Wrap      <= 1'b0;
      s1En        <= 1'b0;
      s2Mag       <= '0;
      s2Neg       <= 1'b0;
      s2Wrap      <= 1'b0;
      s2En        <= 1'b0;
      toDAC       <= '0;
      sampleValid <= 1'b0;
      phaseSync   <= 1'b0;
    end else begin
      s1Idx       <= quad[0] ? ~idx : idx;
      s1Neg       <= quad[1];
      s1Wrap      <= accWrap;
      s1En        <= accEn;
      s2Mag       <= lut[s1Idx];
      s2Neg       <= s1Neg;
      s2Wrap      <= s1Wrap;
      s2En        <= s1En;
      sampleValid <= s2En;
      phaseSync   <= s2En && s2Wrap;
      if (s2En) begin
        toDAC <= s2Neg ? (~magExt) + OUT_W'(1) : magExt;
      end
    end
  end

endmodule

// File: tb/tb_ref_sin_dds.sv
// Bench for ref_sin_dds: directed table, corner sequences and a
// randomized run against a phase/frequency model using plain trig.
module tb_ref_sin_dds;

  localparam real PI = 3.14159265358979323846;

  logic               clock;
  logic               reset;
  logic               enable;
  logic               phaseLoad;
  logic [31:0]        phaseOffset;
  logic signed [15:0] toDAC;
  logic               sampleValid;
  logic               phaseSync;

  int checks = 0;
  int failures = 0;

  ref_sin_dds_if #(.ACC_W(32)) fIf();

  ref_sin_dds #(
    .ACC_W(32),
    .LUT_AW(8),
    .OUT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .freqIf(fIf),
    .phaseOffset(phaseOffset),
    .phaseLoad(phaseLoad),
    .toDAC(toDAC),
    .sampleValid(sampleValid),
    .phaseSync(phaseSync)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample = sine at the centre of the 1/1024-turn bin holding the phase.
  function automatic int refSample(input logic [31:0] ph);
    int  bin;
    real s;
    int  m;
    bin = int'(ph[31:22]);
    s = $sin(2.0 * PI * (real'(bin) + 0.5) / 1024.0);
    m = $rtoi(((s < 0.0) ? -s : s) * 32767.0 + 0.5);
    return (s < 0.0) ? -m : m;
  endfunction

  typedef struct {
    bit v;
    bit w;
    int s;
  } tag_t;

  logic [31:0] mPhase;
  logic [31:0] mFtw;
  logic [31:0] mPendWord;
  bit          mPend;
  tag_t        pipe [3];
  int          expDac;
  bit          expSv;
  bit          expSync;
  bit          expAck;

  task automatic modelReset();
    mPhase    = '0;
    mFtw      = '0;
    mPendWord = '0;
    mPend     = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
    expDac  = 0;
    expSv   = 1'b0;
    expSync = 1'b0;
    expAck  = 1'b0;
  endtask

  task automatic modelEdge();
    logic [32:0] total;
    logic [31:0] np;
    bit          carry;
    bit          apply;
    tag_t        t;
    tag_t        o;
    total = {1'b0, mPhase} + {1'b0, mFtw};
    carry = total[32];
    apply = mPend && (carry || phaseLoad || !enable || mFtw == 0);
    if (phaseLoad)   np = phaseOffset;
    else if (enable) np = total[31:0];
    else             np = mPhase;
    t.v = enable;
    t.w = !phaseLoad && enable && carry;
    t.s = refSample(np);
    o = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = t;
    if (o.v) expDac = o.s;
    expSv   = o.v;
    expSync = o.v && o.w;
    expAck  = apply;
    if (apply) begin
      mFtw  = mPendWord;
      mPend = 1'b0;
    end else if (fIf.freqValid && !mPend) begin
      mPendWord = fIf.freq;
      mPend     = 1'b1;
    end
    mPhase = np;
  endtask

  task automatic step();
    @(posedge clock);
    modelEdge();
    #1;
    check("toDAC", toDAC, expDac);
    check("sampleValid", sampleValid, expSv);
    check("phaseSync", phaseSync, expSync);
    check("freqAck", fIf.freqAck, expAck);
  endtask

  task automatic waitAck(input string name, input int maxC);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxC && !seen; i++) begin
      step();
      if (fIf.freqAck) seen = 1'b1;
    end
    fIf.freqValid = 1'b0;
    check(name, seen, 1);
  endtask

  typedef struct {
    bit          en;
    bit          fv;
    logic [31:0] f;
    bit          pl;
    logic [31:0] po;
    int          dac;
    bit          sv;
    bit          sync;
    bit          ack;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int  first;
    int  second;
    int  held;
    bit  ackIdle;
    bit  offering;
    int  ackCnt;

    tbl[0]  = '{1, 1, 32'h4000_0000, 0, 0,      0, 0, 0, 0};
    tbl[1]  = '{1, 1, 32'h4000_0000, 0, 0,      0, 0, 0, 1};
    tbl[2]  = '{1, 0, 32'h0,         0, 0,      0, 0, 0, 0};
    tbl[3]  = '{1, 0, 32'h0,         0, 0,    101, 1, 0, 0};
    tbl[4]  = '{1, 0, 32'h0,         0, 0,    101, 1, 0, 0};
    tbl[5]  = '{1, 0, 32'h0,         0, 0,  32767, 1, 0, 0};
    tbl[6]  = '{1, 0, 32'h0,         0, 0,   -101, 1, 0, 0};
    tbl[7]  = '{1, 0, 32'h0,         0, 0, -32767, 1, 0, 0};
    tbl[8]  = '{1, 0, 32'h0,         0, 0,    101, 1, 1, 0};
    tbl[9]  = '{1, 0, 32'h0,         0, 0,  32767, 1, 0, 0};
    tbl[10] = '{1, 0, 32'h0,         0, 0,   -101, 1, 0, 0};
    tbl[11] = '{1, 0, 32'h0,         0, 0, -32767, 1, 0, 0};
    tbl[12] = '{1, 0, 32'h0,         0, 0,    101, 1, 1, 0};

    reset = 1'b1;
    enable = 1'b0;
    phaseLoad = 1'b0;
    phaseOffset = '0;
    fIf.freq = '0;
    fIf.freqValid = 1'b0;
    #1;
    check("reset_toDAC", toDAC, 0);
    check("reset_sampleValid", sampleValid, 0);
    check("reset_phaseSync", phaseSync, 0);
    check("reset_freqAck", fIf.freqAck, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();

    // T1: quarter-turn tuning word from a zero ftw
    for (int i = 0; i < 13; i++) begin
      enable        = tbl[i].en;
      fIf.freqValid = tbl[i].fv;
      fIf.freq      = tbl[i].f;
      phaseLoad     = tbl[i].pl;
      phaseOffset   = tbl[i].po;
      step();
      check($sformatf("t1_dac[%0d]", i), toDAC, tbl[i].dac);
      check($sformatf("t1_sv[%0d]", i), sampleValid, tbl[i].sv);
      check($sformatf("t1_sync[%0d]", i), phaseSync, tbl[i].sync);
      check($sformatf("t1_ack[%0d]", i), fIf.freqAck, tbl[i].ack);
    end

    // T3: load half a turn on the wrap clock
    phaseLoad = 1'b1;
    phaseOffset = 32'h8000_0000;
    step();
    check("t3_nosync0", phaseSync, 0);
    phaseLoad = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t3_nosync%0d", i), phaseSync, 0);
    end
    check("t3_dac", toDAC, -101);

    // T2: halve the frequency mid-period
    fIf.freq = 32'h2000_0000;
    fIf.freqValid = 1'b1;
    waitAck("t2_ack", 20);
    first = -1;
    second = -1;
    for (int n = 1; n <= 30 && second < 0; n++) begin
      step();
      if (phaseSync) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    check("t2_sync_first", first, 3);
    check("t2_sync_second", second, 11);

    // T5: word held while pending, second word only after ack
    fIf.freq = 32'h4000_0000;
    fIf.freqValid = 1'b1;
    waitAck("t5_ackA", 20);
    fIf.freq = 32'h1000_0000;
    fIf.freqValid = 1'b1;
    step();
    waitAck("t5_ackB", 20);

    // T4: ten idle clocks with a word applied during idle
    enable = 1'b0;
    step();
    step();
    step();
    held = expDac;
    check("t4_sv_tail", sampleValid, 1);
    step();
    check("t4_sv_low", sampleValid, 0);
    check("t4_dac_hold", toDAC, held);
    ackIdle = 1'b0;
    fIf.freq = 32'h0800_0000;
    fIf.freqValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fIf.freqAck) begin
        ackIdle = 1'b1;
        fIf.freqValid = 1'b0;
      end
      check("t4_dac_hold", toDAC, held);
      check("t4_sv_idle", sampleValid, 0);
    end
    check("t4_idle_ack", ackIdle, 1);
    fIf.freqValid = 1'b0;
    enable = 1'b1;
    repeat (12) step();

    // randomized run against the model
    offering = 1'b0;
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      phaseLoad = ($urandom_range(0, 15) == 0);
      phaseOffset = $urandom;
      if (!offering && $urandom_range(0, 3) == 0) begin
        offering = 1'b1;
        fIf.freq = $urandom >> $urandom_range(0, 8);
        fIf.freqValid = 1'b1;
      end
      step();
      if (fIf.freqAck) begin
        offering = 1'b0;
        fIf.freqValid = 1'b0;
      end
    end
    phaseLoad = 1'b0;
    enable = 1'b1;
    fIf.freqValid = 1'b0;
    repeat (6) step();

    // T6: reset while a word is pending
    fIf.freq = 32'h0300_0000;
    fIf.freqValid = 1'b1;
    step();
    #3;
    reset = 1'b1;
    fIf.freqValid = 1'b0;
    #1;
    check("t6_toDAC", toDAC, 0);
    check("t6_sampleValid", sampleValid, 0);
    check("t6_phaseSync", phaseSync, 0);
    check("t6_freqAck", fIf.freqAck, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
    ackCnt = 0;
    repeat (10) begin
      step();
      if (fIf.freqAck) ackCnt++;
    end
    check("t6_no_ack", ackCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
